// File: rtl/avalon_dual_master_arbiter.sv
// Two Avalon-MM masters sharing one slave; round-robin grant, lock, timeout.
// Ports: clk_clk, reset_reset_n, a_*/b_* master ports, s_* slave port,
//   grant_a/grant_b owner status, arb_timeout forced-release pulse.
module avalon_dual_master_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              a_read,
    input  logic              a_write,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_writedata,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_waitrequest,
    input  logic              b_read,
    input  logic              b_write,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] b_writedata,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_waitrequest,
    output logic              s_read,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest,
    output logic              grant_a,
    output logic              grant_b,
    output logic              arb_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;
    logic [7:0]  wait_q, wait_d;

    logic              req_a, req_b;
    logic              m_read, m_write, m_lock;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              cmd, stall, done, tmo;

    assign req_a = a_read | a_write | a_lock;
    assign req_b = b_read | b_write | b_lock;

    // Signals of whichever master currently owns the slave.
    assign m_read  = (state_q == GNT_A) ? a_read      : b_read;
    assign m_write = (state_q == GNT_A) ? a_write     : b_write;
    assign m_lock  = (state_q == GNT_A) ? a_lock      : b_lock;
    assign m_addr  = (state_q == GNT_A) ? a_address   : b_address;
    assign m_wdata = (state_q == GNT_A) ? a_writedata : b_writedata;

    assign cmd   = (state_q != IDLE) & (m_read | m_write);
    assign stall = cmd & s_waitrequest;
    assign done  = cmd & ~s_waitrequest;
    assign tmo   = stall & (wait_q == TMO);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            wait_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_b_d      = last_b_q;
        wait_d        = wait_q;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_address     = '0;
        s_writedata   = '0;
        a_readdata    = '0;
        b_readdata    = '0;
        a_waitrequest = 1'b1;
        b_waitrequest = 1'b1;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        arb_timeout   = 1'b0;

        unique case (state_q)
            IDLE: begin
                wait_d = 8'd0;
                // On contention the master that did not own last wins.
                if (req_a && (!req_b || last_b_q)) begin
                    state_d  = GNT_A;
                    last_b_d = 1'b0;
                end else if (req_b) begin
                    state_d  = GNT_B;
                    last_b_d = 1'b1;
                end
            end
            GNT_A, GNT_B: begin
                grant_a     = (state_q == GNT_A);
                grant_b     = (state_q == GNT_B);
                s_address   = m_addr;
                s_writedata = m_wdata;
                if (tmo) begin
                    // Forced release: drop the slave command, error data.
                    arb_timeout = 1'b1;
                    state_d     = IDLE;
                    wait_d      = 8'd0;
                    if (state_q == GNT_A) begin
                        a_readdata    = '1;
                        a_waitrequest = 1'b0;
                    end else begin
                        b_readdata    = '1;
                        b_waitrequest = 1'b0;
                    end
                end else begin
                    // Write wins when read and write are both high.
                    s_write = m_write;
                    s_read  = m_read & ~m_write;
                    if (state_q == GNT_A) begin
                        a_readdata    = s_readdata;
                        a_waitrequest = s_waitrequest;
                    end else begin
                        b_readdata    = s_readdata;
                        b_waitrequest = s_waitrequest;
                    end
                    if (done) begin
                        wait_d = 8'd0;
                        if (!m_lock) state_d = IDLE;
                    end else if (stall) begin
                        if (wait_q != TMO) wait_d = wait_q + 8'd1;
                    end else if (!m_lock) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_avalon_dual_master_arbiter.sv
// Bench for avalon_dual_master_arbiter: directed scenarios plus random
// traffic checked against a transaction-level owner/last/wait model.
module tb_avalon_dual_master_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_read, a_write, a_lock;
    logic [AW-1:0] a_address;
    logic [DW-1:0] a_writedata, a_readdata;
    logic          a_waitrequest;
    logic          b_read, b_write, b_lock;
    logic [AW-1:0] b_address;
    logic [DW-1:0] b_writedata, b_readdata;
    logic          b_waitrequest;
    logic          s_read, s_write;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_writedata, s_readdata;
    logic          s_waitrequest;
    logic          grant_a, grant_b, arb_timeout;

    int checks   = 0;
    int failures = 0;

    // Model: own 0=none 1=A 2=B; last 1=A 2=B; mw = stalled cycles seen.
    int own  = 0;
    int last = 2;
    int mw   = 0;
    int stuck = 0;

    always #10 clk = ~clk;

    avalon_dual_master_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .a_read        (a_read),
        .a_write       (a_write),
        .a_lock        (a_lock),
        .a_address     (a_address),
        .a_writedata   (a_writedata),
        .a_readdata    (a_readdata),
        .a_waitrequest (a_waitrequest),
        .b_read        (b_read),
        .b_write       (b_write),
        .b_lock        (b_lock),
        .b_address     (b_address),
        .b_writedata   (b_writedata),
        .b_readdata    (b_readdata),
        .b_waitrequest (b_waitrequest),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_address     (s_address),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .grant_a       (grant_a),
        .grant_b       (grant_b),
        .arb_timeout   (arb_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        a_read = 0; a_write = 0; a_lock = 0;
        b_read = 0; b_write = 0; b_lock = 0;
        a_address = '0; b_address = '0;
        a_writedata = '0; b_writedata = '0;
        s_readdata = '0; s_waitrequest = 0;
    endtask

    // Settle after input drive, then compare every output with the model.
    task automatic settle_check();
        logic          rd, wr, cmd, tmo;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd, ordata;
        logic          owait, xwait;
        #1;
        chk("grant_a", grant_a, own == 1);
        chk("grant_b", grant_b, own == 2);
        if (own == 0) begin
            chk("idle_s_read", s_read, 0);
            chk("idle_s_write", s_write, 0);
            chk("idle_timeout", arb_timeout, 0);
            if (a_read | a_write | a_lock) chk("idle_a_wait", a_waitrequest, 1);
            if (b_read | b_write | b_lock) chk("idle_b_wait", b_waitrequest, 1);
        end else begin
            rd     = (own == 1) ? a_read : b_read;
            wr     = (own == 1) ? a_write : b_write;
            ad     = (own == 1) ? a_address : b_address;
            wd     = (own == 1) ? a_writedata : b_writedata;
            ordata = (own == 1) ? a_readdata : b_readdata;
            owait  = (own == 1) ? a_waitrequest : b_waitrequest;
            xwait  = (own == 1) ? b_waitrequest : a_waitrequest;
            cmd = rd | wr;
            tmo = cmd && s_waitrequest && (mw >= TMO);
            chk("timeout", arb_timeout, tmo);
            chk("s_read", s_read, tmo ? 1'b0 : (rd && !wr));
            chk("s_write", s_write, tmo ? 1'b0 : wr);
            chk("s_address", s_address, ad);
            chk("s_writedata", s_writedata, wd);
            chk("owner_wait", owait, tmo ? 1'b0 : s_waitrequest);
            chk("owner_rdata", ordata, tmo ? 32'hFFFF_FFFF : s_readdata);
            chk("other_wait", xwait, 1);
        end
    endtask

    // Apply the clock edge to the model, then move to the next negedge.
    task automatic model_advance();
        logic ra, rb, cmd, lk, tmo;
        if (own == 0) begin
            ra = a_read | a_write | a_lock;
            rb = b_read | b_write | b_lock;
            if (ra && (!rb || last == 2)) own = 1;
            else if (rb) own = 2;
            if (own != 0) last = own;
            mw = 0;
        end else begin
            cmd = (own == 1) ? (a_read | a_write) : (b_read | b_write);
            lk  = (own == 1) ? a_lock : b_lock;
            tmo = cmd && s_waitrequest && (mw >= TMO);
            if (tmo) begin
                own = 0;
                mw  = 0;
            end else if (cmd && !s_waitrequest) begin
                mw = 0;
                if (!lk) own = 0;
            end else if (cmd) begin
                if (mw < TMO) mw++;
            end else if (!lk) begin
                own = 0;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_grant_a", grant_a, 0);
        chk("rst_grant_b", grant_b, 0);
        chk("rst_timeout", arb_timeout, 0);
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        if (a_read | a_write | a_lock) chk("rst_a_wait", a_waitrequest, 1);
        if (b_read | b_write | b_lock) chk("rst_b_wait", b_waitrequest, 1);
        own = 0; last = 2; mw = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic random_inputs();
        a_read  = ($urandom_range(0, 99) < 40);
        a_write = ($urandom_range(0, 99) < 30);
        a_lock  = ($urandom_range(0, 99) < 12);
        b_read  = ($urandom_range(0, 99) < 40);
        b_write = ($urandom_range(0, 99) < 30);
        b_lock  = ($urandom_range(0, 99) < 12);
        a_address   = AW'($urandom);
        b_address   = AW'($urandom);
        a_writedata = $urandom;
        b_writedata = $urandom;
        s_readdata  = $urandom;
        if (stuck > 0) begin
            stuck--;
            s_waitrequest = 1;
        end else if ($urandom_range(0, 99) < 4) begin
            stuck = 12;
            s_waitrequest = 1;
        end else begin
            s_waitrequest = ($urandom_range(0, 99) < 35);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        do_reset();

        // Single master read.
        a_read = 1; a_address = 8'h10;
        s_readdata = 32'h1234_5678; s_waitrequest = 0;
        settle_check();
        chk("r1_idle_sread", s_read, 0);
        model_advance();
        settle_check();
        chk("r1_sread", s_read, 1);
        chk("r1_addr", s_address, 8'h10);
        chk("r1_rdata", a_readdata, 32'h1234_5678);
        chk("r1_wait", a_waitrequest, 0);
        model_advance();
        a_read = 0;
        settle_check();
        chk("r1_back_idle", grant_a, 0);
        model_advance();

        // Contention: alternating grants with one idle bubble.
        do_reset();
        a_write = 1; b_write = 1;
        a_writedata = 32'hAAAA_0001; b_writedata = 32'hBBBB_0002;
        for (int i = 0; i < 8; i++) begin
            settle_check();
            chk("c_grant_a", grant_a, (i == 1) || (i == 5));
            chk("c_grant_b", grant_b, (i == 3) || (i == 7));
            if (grant_a) chk("c_b_wait", b_waitrequest, 1);
            model_advance();
        end
        clear_inputs();
        settle_check();
        model_advance();

        // Lock: four back-to-back writes, then B gets the slave.
        do_reset();
        b_write = 1;
        for (int i = 0; i < 7; i++) begin
            a_lock = (i < 4);
            a_write = (i < 5);
            a_writedata = (i == 0) ? 32'd0 : 32'(i - 1);
            settle_check();
            if (i >= 1 && i <= 4) begin
                chk("l_grant_a", grant_a, 1);
                chk("l_s_write", s_write, 1);
                chk("l_wdata", s_writedata, 32'(i - 1));
                chk("l_b_wait", b_waitrequest, 1);
            end
            if (i == 5) chk("l_bubble", {grant_a, grant_b}, 2'b00);
            if (i == 6) chk("l_grant_b", grant_b, 1);
            model_advance();
        end
        clear_inputs();
        settle_check();
        model_advance();

        // Timeout on a stuck B read.
        do_reset();
        b_read = 1; s_waitrequest = 1; s_readdata = 32'hA5A5_5A5A;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) b_read = 0;
            settle_check();
            if (i >= 1 && i <= 8) begin
                chk("t_no_pulse", arb_timeout, 0);
                chk("t_b_wait", b_waitrequest, 1);
            end
            if (i == 9) begin
                chk("t_pulse", arb_timeout, 1);
                chk("t_rdata", b_readdata, 32'hFFFF_FFFF);
                chk("t_b_wait0", b_waitrequest, 0);
                chk("t_s_read", s_read, 0);
            end
            if (i == 10) chk("t_idle", grant_b, 0);
            model_advance();
        end

        // Reset in the middle of a stalled B transfer.
        do_reset();
        b_read = 1; s_waitrequest = 1;
        settle_check();
        model_advance();
        settle_check();
        chk("m_s_read", s_read, 1);
        chk("m_grant_b", grant_b, 1);
        #2;
        do_reset();
        a_read = 1; b_read = 1; s_waitrequest = 0;
        settle_check();
        model_advance();
        settle_check();
        chk("m_a_wins", grant_a, 1);
        model_advance();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            random_inputs();
            settle_check();
            model_advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
